cyclic_prefix_insert: RTL and testbench

- Sits directly downstream of myFFT in TYPE("invers") mode, on the OFDM transmit path.
- Captures each NFFT-sample IFFT output symbol into a ping-pong buffer.
- Re-emits each symbol with its last CP_LEN samples prepended as the cyclic prefix: NFFT+CP_LEN output samples per symbol.
- Gapless back-to-back output when the next symbol is already buffered.

---
 rtl/cyclic_prefix_insert.sv | 192 +++++++++++++++++++
 tb/tb_cyclic_prefix_insert.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cyclic_prefix_insert.sv
// Ping-pong symbol buffer that re-emits each NFFT-sample IFFT symbol with its
// last CP_LEN samples prepended as the cyclic prefix.
module cyclic_prefix_insert #(
    parameter int SIZE_BUFFER = 6,
    parameter int CP_LEN      = 16,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic [DATA_WIDTH-1:0] data_in_q,
    output logic                  flag_wayt_data,
    output logic [DATA_WIDTH-1:0] data_out_i,
    output logic [DATA_WIDTH-1:0] data_out_q,
    output logic                  valid_out,
    input  logic                  flag_ready_recive,
    output logic                  symbol_start,
    output logic                  overflow
);

    localparam int NFFT = 2 ** SIZE_BUFFER;
    localparam logic [SIZE_BUFFER-1:0] ADDR_LAST = '1;
    localparam logic [SIZE_BUFFER-1:0] ADDR_CP   = SIZE_BUFFER'(NFFT - CP_LEN);

    if (CP_LEN < 1 || CP_LEN >= NFFT) begin : g_bad_cp_len
        $error("cyclic_prefix_insert: CP_LEN must lie in 1..NFFT-1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFIX,
        ST_BODY
    } state_t;

    // Bank b occupies entries {b, addr}
    logic [2*DATA_WIDTH-1:0] mem_q [2*NFFT];

    logic [SIZE_BUFFER-1:0] wr_addr_q, wr_addr_d;
    logic                   wr_bank_q, wr_bank_d;
    logic [1:0]             full_q, full_d;
    logic                   overflow_q, overflow_d;
    logic                   wr_accept;

    state_t                 state_q, state_d;
    logic [SIZE_BUFFER-1:0] rd_addr_q, rd_addr_d;
    logic                   rd_bank_q, rd_bank_d;
    logic                   valid_out_q, valid_out_d;
    logic                   symbol_start_q, symbol_start_d;
    logic [DATA_WIDTH-1:0]  dout_i_q, dout_i_d;
    logic [DATA_WIDTH-1:0]  dout_q_q, dout_q_d;

    logic                   adv;
    logic                   start;
    logic                   load;
    logic [SIZE_BUFFER-1:0] load_addr;
    logic                   rd_release;

    assign flag_wayt_data = ~full_q[wr_bank_q];
    assign wr_accept      = valid & flag_wayt_data;
    assign adv            = ~valid_out_q | flag_ready_recive;

    assign data_out_i   = dout_i_q;
    assign data_out_q   = dout_q_q;
    assign valid_out    = valid_out_q;
    assign symbol_start = symbol_start_q;
    assign overflow     = overflow_q;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[{wr_bank_q, wr_addr_q}] <= {data_in_i, data_in_q};
        end
    end

    // Write-side set and read-side release never target the same bank on one edge
    always_comb begin
        wr_addr_d  = wr_addr_q;
        wr_bank_d  = wr_bank_q;
        full_d     = full_q;
        overflow_d = valid & ~flag_wayt_data;
        if (wr_accept) begin
            wr_addr_d = wr_addr_q + 1'b1;
            if (wr_addr_q == ADDR_LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (rd_release) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    // In BODY with rd_addr_q == ADDR_LAST the symbol is finished and the bank released
    always_comb begin
        state_d        = state_q;
        rd_addr_d      = rd_addr_q;
        rd_bank_d      = rd_bank_q;
        valid_out_d    = valid_out_q;
        symbol_start_d = symbol_start_q;
        dout_i_d       = dout_i_q;
        dout_q_d       = dout_q_q;
        start          = 1'b0;
        load           = 1'b0;
        load_addr      = rd_addr_q;
        rd_release     = 1'b0;
        if (adv) begin
            case (state_q)
                ST_IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        start = 1'b1;
                    end else begin
                        valid_out_d    = 1'b0;
                        symbol_start_d = 1'b0;
                    end
                end
                ST_PREFIX: begin
                    load           = 1'b1;
                    symbol_start_d = 1'b0;
                    if (rd_addr_q == ADDR_LAST) begin
                        load_addr = '0;
                        state_d   = ST_BODY;
                    end else begin
                        load_addr = rd_addr_q + 1'b1;
                    end
                end
                ST_BODY: begin
                    if (rd_addr_q == ADDR_LAST) begin
                        if (full_q[rd_bank_q]) begin
                            start = 1'b1;
                        end else begin
                            valid_out_d    = 1'b0;
                            symbol_start_d = 1'b0;
                            state_d        = ST_IDLE;
                        end
                    end else begin
                        load      = 1'b1;
                        load_addr = rd_addr_q + 1'b1;
                        if (load_addr == ADDR_LAST) begin
                            rd_release = 1'b1;
                            rd_bank_d  = ~rd_bank_q;
                        end
                    end
                end
                default: begin
                    valid_out_d    = 1'b0;
                    symbol_start_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            endcase
            if (start) begin
                load           = 1'b1;
                load_addr      = ADDR_CP;
                symbol_start_d = 1'b1;
                state_d        = ST_PREFIX;
            end
            if (load) begin
                rd_addr_d              = load_addr;
                valid_out_d            = 1'b1;
                {dout_i_d, dout_q_d}   = mem_q[{rd_bank_q, load_addr}];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_addr_q      <= '0;
            wr_bank_q      <= 1'b0;
            full_q         <= '0;
            overflow_q     <= 1'b0;
            state_q        <= ST_IDLE;
            rd_addr_q      <= '0;
            rd_bank_q      <= 1'b0;
            valid_out_q    <= 1'b0;
            symbol_start_q <= 1'b0;
            dout_i_q       <= '0;
            dout_q_q       <= '0;
        end else begin
            wr_addr_q      <= wr_addr_d;
            wr_bank_q      <= wr_bank_d;
            full_q         <= full_d;
            overflow_q     <= overflow_d;
            state_q        <= state_d;
            rd_addr_q      <= rd_addr_d;
            rd_bank_q      <= rd_bank_d;
            valid_out_q    <= valid_out_d;
            symbol_start_q <= symbol_start_d;
            dout_i_q       <= dout_i_d;
            dout_q_q       <= dout_q_d;
        end
    end

endmodule

// File: tb/tb_cyclic_prefix_insert.sv
// Scoreboard bench: a small instance (NFFT=8, CP=2) under directed and random
// traffic, plus a default-parameter instance fed a ramp.
module tb_cyclic_prefix_insert;

    localparam int N  = 8;
    localparam int CP = 2;
    localparam int NB = 64;
    localparam int CB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        valid_s = 1'b0;
    logic [15:0] di_s = '0, dq_s = '0;
    logic        flag_s, vo_s, ss_s, ovf_s;
    logic [15:0] doi_s, doq_s;
    logic        ready_s = 1'b1;

    logic        valid_b = 1'b0;
    logic [15:0] di_b = '0, dq_b = '0;
    logic        flag_b, vo_b, ss_b, ovf_b;
    logic [15:0] doi_b, doq_b;
    logic        ready_b = 1'b1;

    cyclic_prefix_insert #(.SIZE_BUFFER(3), .CP_LEN(CP), .DATA_WIDTH(16)) dut_s (
        .clk(clk), .reset(reset), .valid(valid_s), .data_in_i(di_s), .data_in_q(dq_s),
        .flag_wayt_data(flag_s), .data_out_i(doi_s), .data_out_q(doq_s), .valid_out(vo_s),
        .flag_ready_recive(ready_s), .symbol_start(ss_s), .overflow(ovf_s));

    cyclic_prefix_insert dut_b (
        .clk(clk), .reset(reset), .valid(valid_b), .data_in_i(di_b), .data_in_q(dq_b),
        .flag_wayt_data(flag_b), .data_out_i(doi_b), .data_out_q(doq_b), .valid_out(vo_b),
        .flag_ready_recive(ready_b), .symbol_start(ss_b), .overflow(ovf_b));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
        logic        sof;
    } exp_t;

    exp_t        expq[$];
    exp_t        expb[$];
    logic [15:0] part_i[$];
    logic [15:0] part_q[$];

    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0;
    int flag_low_cnt = 0;
    int run = 0;
    int last_run = 0;
    int popped_b = 0;
    int ready_mode = 1;
    int pat = 0;
    logic exp_ovf = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a symbol becomes output only once all N samples are in
    always @(negedge clk) begin
        if (!reset) begin
            part_i.delete();
            part_q.delete();
            expq.delete();
            exp_ovf = 1'b0;
        end else begin
            chk("overflow", ovf_s, exp_ovf);
            if (ovf_s) ovf_cnt++;
            if (!flag_s) flag_low_cnt++;
            exp_ovf = valid_s && !flag_s;
            if (valid_s && flag_s) begin
                part_i.push_back(di_s);
                part_q.push_back(dq_s);
                if (part_i.size() == N) begin
                    for (int k = N - CP; k < N; k++)
                        expq.push_back('{part_i[k], part_q[k], k == N - CP});
                    for (int k = 0; k < N; k++)
                        expq.push_back('{part_i[k], part_q[k], 1'b0});
                    part_i.delete();
                    part_q.delete();
                end
            end
        end
    end

    logic        hold = 1'b0;
    logic [15:0] hi, hq;
    logic        hs;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            hold = 1'b0;
            run  = 0;
        end else begin
            if (hold) begin
                chk("hold_valid", vo_s, 1'b1);
                chk("hold_i", doi_s, hi);
                chk("hold_q", doq_s, hq);
                chk("hold_sof", ss_s, hs);
            end
            if (vo_s) run++;
            else if (run > 0) begin
                last_run = run;
                run = 0;
            end
            hold = 1'b0;
            if (vo_s) begin
                if (ready_s) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_out actual=%0h expected=none", doi_s);
                    end else begin
                        e = expq.pop_front();
                        chk("out_i", doi_s, e.i);
                        chk("out_q", doq_s, e.q);
                        chk("out_sof", ss_s, e.sof);
                    end
                end else begin
                    hold = 1'b1;
                    hi = doi_s;
                    hq = doq_s;
                    hs = ss_s;
                end
            end else begin
                chk("sof_idle", ss_s, 1'b0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset && vo_b) begin
            if (expb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL big_spurious actual=%0h expected=none", doi_b);
            end else begin
                e = expb.pop_front();
                chk("big_i", doi_b, e.i);
                chk("big_q", doq_b, e.q);
                chk("big_sof", ss_b, e.sof);
                popped_b++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: ready_s = 1'b0;
            2: begin
                ready_s = (pat == 0) || (pat == 3);
                pat = (pat + 1) % 4;
            end
            3: ready_s = ($urandom_range(0, 2) != 0);
            default: ready_s = 1'b1;
        endcase
    end

    task automatic send_sym(input logic [15:0] i0, input logic [15:0] q0);
        int to;
        for (int k = 0; k < N; k++) begin
            to = 0;
            while (!flag_s && to < 300) begin
                valid_s = 1'b0;
                cyc();
                to++;
            end
            if (to >= 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=flag_low expected=flag_high");
            end
            valid_s = 1'b1;
            di_s = i0 + 16'(k);
            dq_s = q0 + 16'(k);
            cyc();
        end
        valid_s = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((expq.size() != 0 || vo_s) && n < 1000) begin
            cyc();
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d expected=0", name, expq.size());
        end
        cyc();
    endtask

    initial begin
        int base, fbase, n;
        #12;
        chk("rst_valid", vo_s, 1'b0);
        chk("rst_sof", ss_s, 1'b0);
        chk("rst_ovf", ovf_s, 1'b0);
        chk("rst_data", {doi_s, doq_s}, '0);
        chk("rst_flag", flag_s, 1'b1);
        chk("rst_big_flag", flag_b, 1'b1);
        cyc();
        reset = 1'b1;
        cyc();

        send_sym(16'd1, 16'h10);
        chk("lat_pre", vo_s, 1'b0);
        cyc();
        chk("lat_first", vo_s, 1'b1);
        chk("lat_sof", ss_s, 1'b1);
        chk("lat_i", doi_s, 16'd7);
        drain("sym1");
        chk("run_one_symbol", last_run, 10);

        base = ovf_cnt;
        fbase = flag_low_cnt;
        send_sym(16'h21, 16'h31);
        send_sym(16'h41, 16'h51);
        send_sym(16'h61, 16'h71);
        drain("three");
        chk("run_three_symbols", last_run, 30);
        chk("flag_dropped", flag_low_cnt > fbase, 1'b1);
        chk("no_ovf_three", ovf_cnt - base, 0);

        ready_mode = 0;
        send_sym(16'h100, 16'h180);
        send_sym(16'h200, 16'h280);
        cyc();
        chk("flag_full", flag_s, 1'b0);
        base = ovf_cnt;
        for (int k = 0; k < 3; k++) begin
            valid_s = 1'b1;
            di_s = 16'hDEA0 + 16'(k);
            dq_s = 16'hBEE0 + 16'(k);
            cyc();
        end
        valid_s = 1'b0;
        cyc();
        cyc();
        chk("ovf_pulses", ovf_cnt - base, 3);
        ready_mode = 1;
        drain("ovf");

        ready_mode = 2;
        send_sym(16'h300, 16'h380);
        drain("toggle");
        ready_mode = 1;
        cyc();

        send_sym(16'h50, 16'h60);
        cyc();
        chk("pre_rst_prefix", ss_s, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("async_valid", vo_s, 1'b0);
        chk("async_sof", ss_s, 1'b0);
        chk("async_flag", flag_s, 1'b1);
        cyc();
        reset = 1'b1;
        cyc();
        send_sym(16'd9, 16'h19);
        drain("post_reset");
        chk("run_post_reset", last_run, 10);

        ready_mode = 3;
        for (int c = 0; c < 400; c++) begin
            valid_s = ($urandom_range(0, 3) != 0);
            di_s = 16'($urandom);
            dq_s = 16'($urandom);
            cyc();
        end
        valid_s = 1'b0;
        ready_mode = 1;
        drain("random");

        for (int k = NB - CB; k < NB; k++) expb.push_back('{16'(k), 16'(k + 256), k == NB - CB});
        for (int k = 0; k < NB; k++) expb.push_back('{16'(k), 16'(k + 256), 1'b0});
        for (int k = 0; k < NB; k++) begin
            n = 0;
            while (!flag_b && n < 300) begin
                valid_b = 1'b0;
                cyc();
                n++;
            end
            valid_b = 1'b1;
            di_b = 16'(k);
            dq_b = 16'(k + 256);
            cyc();
        end
        valid_b = 1'b0;
        n = 0;
        while ((expb.size() != 0 || vo_b) && n < 500) begin
            cyc();
            n++;
        end
        chk("big_count", popped_b, 80);
        chk("small_queue_empty", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
